restoring_divider8: RTL

Sequential unsigned 8-bit divider for the calculator datapath. Each cycle it performs one shift-and-trial-subtract step, producing one quotient bit, and finishes in 8 cycles. A divide-by-zero operand is flagged and completes early. The block is the inverse-operation companion to the 8-bit adder: the ALU sequencer starts it with a one-cycle pulse and collects the quotient and remainder when `done` asserts.

---
 rtl/restoring_divider8_pkg.sv | 16 +
 rtl/restoring_divider8_trial_sub.sv | 23 ++
 rtl/restoring_divider8.sv | 118 +++++++++++
 3 files changed

// File: rtl/restoring_divider8_pkg.sv
// Shared constants and state type for the restoring divider.
package restoring_divider8_pkg;

    localparam int DIV_W     = 8;
    localparam int DIV_STEPS = 8;

    // Quotient reported when the divisor is zero (all ones, as if "infinite").
    localparam logic [DIV_W-1:0] DIV0_QUOTIENT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/restoring_divider8_trial_sub.sv
// Trial subtraction for one restoring-division step: diff = a - b as a + ~b + 1.
// Kept separate so a faster adder structure can replace it without touching the FSM.
module div_trial_sub
    import restoring_divider8_pkg::*;
#(
    parameter int W = DIV_W + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] sum;

    // One extra bit of width exposes the carry; no carry out means a borrow.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        diff   = sum[W-1:0];
        borrow = ~sum[W];
    end

endmodule

// File: rtl/restoring_divider8.sv
// Sequential unsigned divider: one shift-and-trial-subtract step per clock.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one quotient bit per cycle, DIV_STEPS cycles
// DONE  | done pulse cycle; a new start is accepted here as in IDLE
module restoring_divider8
    import restoring_divider8_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                CNT_W     = $clog2(DIV_STEPS);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DIV_STEPS - 1);

    div_state_t       state;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] step_cnt;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    // R[WIDTH] is always 0 after a step (R < D), so it never feeds the next shift.
    logic rem_msb_unused;
    assign rem_msb_unused = rem_q[WIDTH];

    // Shift the next dividend bit into the partial remainder.
    always_comb begin
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    end

    div_trial_sub #(.W(WIDTH + 1)) u_trial_sub (
        .a      (shifted),
        .b      ({1'b0, dvs_q}),
        .diff   (trial),
        .borrow (borrow)
    );

    // Restore on borrow, otherwise keep the difference; quotient bit is !borrow.
    always_comb begin
        rem_next = borrow ? shifted : trial;
        quo_next = {quo_q[WIDTH-2:0], ~borrow};
    end

    // FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            step_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    rem_q    <= rem_next;
                    quo_q    <= quo_next;
                    step_cnt <= step_cnt + CNT_W'(1);
                    if (step_cnt == LAST_STEP) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= quo_next;
                        remainder <= rem_next[WIDTH-1:0];
                    end
                end
                default: begin
                    if (start) begin
                        rem_q       <= '0;
                        quo_q       <= dividend;
                        dvs_q       <= divisor;
                        step_cnt    <= '0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            // Zero divisor short-circuits straight to a result.
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= WIDTH'(DIV0_QUOTIENT);
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
